// File: rtl/c_wdemux.sv
// Write-side demux for the CONV result stream: steers each beat to RAM1 or RAM2,
// generates sequential write addresses and masks unused lanes.
module c_wdemux #(
  parameter int DW  = 8,
  parameter int DN  = 8,
  parameter int AW  = 14,
  parameter int IFW = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IFW-1:0]     winfo,
  input  logic [AW-1:0]      base_addr,
  input  logic [DN*DW-1:0]   m_data,
  input  logic               m_data_first,
  input  logic               m_data_last,
  input  logic               m_data_valid,
  output logic               m_data_ready,
  output logic [AW-1:0]      s_addr,
  output logic [DN*DW-1:0]   s_data,
  output logic               s_data_first,
  output logic               s_data_last,
  output logic               s_data_valid1,
  input  logic               s_data_ready1,
  output logic               s_data_valid2,
  input  logic               s_data_ready2,
  output logic               busy,
  output logic               done,
  output logic               ovf_err,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a beat moves when valid & ready are both high at a rising edge;
  // a valid source keeps its payload stable until that happens.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [2:0]          chan_q;
  logic                ramsel_q;
  logic [AW-1:0]       addr_cnt_q;
  logic                hold_v_q;
  logic [AW-1:0]       s_addr_q;
  logic [DN*DW-1:0]    s_data_q;
  logic                first_q, last_q;
  logic                ovf_q;

  logic                ready_sel, take, accept, start_ok;
  logic [DN*DW-1:0]    masked_data;
  logic                unused_winfo;

  assign unused_winfo = ^{winfo[3], winfo[1:0]};

  assign ready_sel = ramsel_q ? s_data_ready2 : s_data_ready1;
  assign take      = hold_v_q & ready_sel;
  assign start_ok  = (state_q == S_IDLE) & start;
  assign accept    = m_data_valid & m_data_ready;

  // Channel k keeps lanes 0..k-1; channel 0 means every lane is live.
  always_comb begin
    masked_data = m_data;
    for (int i = 0; i < DN; i++) begin
      if ((chan_q != 3'd0) && (i >= int'(chan_q))) begin
        masked_data[i*DW +: DW] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && m_data_last) state_d = S_DRAIN;
      S_DRAIN: if (!hold_v_q || take) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_data_ready = (state_q == S_RUN) & (~hold_v_q | ready_sel);
    busy         = (state_q == S_RUN) | (state_q == S_DRAIN);
    done         = (state_q == S_DONE);
    dbg_state_o  = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_q     <= '0;
      ramsel_q   <= 1'b0;
      addr_cnt_q <= '0;
      hold_v_q   <= 1'b0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        chan_q     <= winfo[6:4];
        ramsel_q   <= winfo[2];
        addr_cnt_q <= base_addr;
        ovf_q      <= 1'b0;
      end
      // Accept and drain may coincide; the new beat simply replaces the old one.
      if (accept) begin
        hold_v_q   <= 1'b1;
        s_addr_q   <= addr_cnt_q;
        s_data_q   <= masked_data;
        first_q    <= m_data_first;
        last_q     <= m_data_last;
        addr_cnt_q <= addr_cnt_q + 1'b1;
        if (&addr_cnt_q) ovf_q <= 1'b1;
      end else if (take) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  assign s_addr        = s_addr_q;
  assign s_data        = s_data_q;
  assign s_data_first  = first_q;
  assign s_data_last   = last_q;
  assign s_data_valid1 = hold_v_q & ~ramsel_q;
  assign s_data_valid2 = hold_v_q & ramsel_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_c_wdemux.sv
// Scoreboard bench for c_wdemux: beats accepted on the input side are modelled
// and queued, then compared against whatever the DUT presents to RAM1/RAM2.
module tb_c_wdemux;

  localparam int DW  = 8;
  localparam int DN  = 8;
  localparam int AW  = 14;
  localparam int IFW = 7;
  localparam int W   = DN*DW;
  localparam int EW  = 1 + AW + W + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IFW-1:0]  winfo;
  logic [AW-1:0]   base_addr;
  logic [W-1:0]    m_data;
  logic            m_data_first, m_data_last, m_data_valid, m_data_ready;
  logic [AW-1:0]   s_addr;
  logic [W-1:0]    s_data;
  logic            s_data_first, s_data_last;
  logic            s_data_valid1, s_data_ready1, s_data_valid2, s_data_ready2;
  logic            busy, done, ovf_err;
  logic [1:0]      dbg_state;

  c_wdemux #(.DW(DW), .DN(DN), .AW(AW), .IFW(IFW)) dut (
    .clk(clk), .rst(rst), .start(start), .winfo(winfo), .base_addr(base_addr),
    .m_data(m_data), .m_data_first(m_data_first), .m_data_last(m_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .s_addr(s_addr), .s_data(s_data), .s_data_first(s_data_first), .s_data_last(s_data_last),
    .s_data_valid1(s_data_valid1), .s_data_ready1(s_data_ready1),
    .s_data_valid2(s_data_valid2), .s_data_ready2(s_data_ready2),
    .busy(busy), .done(done), .ovf_err(ovf_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            step_n  = 0;
  int            last_pop_step = -10;
  logic [W-1:0]  last_sdata = '0;
  bit            prev_acc = 1'b0;
  logic          model_rs = 1'b0;
  logic [2:0]    model_ch = 3'd0;
  logic [AW-1:0] model_addr = '0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_mask(input logic [2:0] ch, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < DN; l++) begin
      if (ch == 3'd0 || l < int'(ch)) r[l*DW +: DW] = d[l*DW +: DW];
    end
    return r;
  endfunction

  // One cycle: inputs were set at the falling edge; sample, score, then advance.
  task automatic step(output bit acc);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    bit            stalled;
    #1;
    acc = m_data_valid && m_data_ready;
    if (!busy) check_eq("mready_idle", 96'(m_data_ready), 96'(1'b0));
    if (model_rs) check_eq("v1_quiet", 96'(s_data_valid1), 96'(1'b0));
    else          check_eq("v2_quiet", 96'(s_data_valid2), 96'(1'b0));
    stalled = (s_data_valid1 && !s_data_ready1) || (s_data_valid2 && !s_data_ready2);
    if (stalled) check_eq("mready_stall", 96'(m_data_ready), 96'(1'b0));
    if (prev_acc) check_eq("lat1", 96'(s_data_valid1 | s_data_valid2), 96'(1'b1));
    if (s_data_valid1 || s_data_valid2) begin
      got = {s_data_valid2, s_addr, s_data, s_data_first, s_data_last};
      if (exp_q.size() == 0) begin
        check_eq("sb_count", 96'(exp_q.size()), 96'(1));
      end else begin
        check_eq("beat", 96'(got), 96'(exp_q[0]));
        if ((s_data_valid1 && s_data_ready1) || (s_data_valid2 && s_data_ready2)) begin
          e = exp_q.pop_front();
          last_sdata = s_data;
          if (e[0]) last_pop_step = step_n;
        end
      end
    end
    if (acc) begin
      exp_q.push_back({model_rs, model_addr, lane_mask(model_ch, m_data), m_data_first, m_data_last});
      model_addr = model_addr + 1'b1;
    end
    prev_acc = acc && !rst;
    step_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: one complete job
  task automatic run_job(input logic [AW-1:0] base, input bit rs, input logic [2:0] ch,
                         input int nb, input bit all_ff, input int stall_from,
                         input int stall_len, input int restart_at, input bit exp_ovf);
    bit           acc;
    bit           trdy;
    int           i;
    int           cyc;
    int           w;
    logic [W-1:0] d;
    winfo = {ch, 1'b1, rs, 2'b11};
    base_addr = base;
    start = 1'b1;
    m_data_valid = 1'b0;
    s_data_ready1 = 1'b1;
    s_data_ready2 = 1'b1;
    model_rs = rs;
    model_ch = ch;
    model_addr = base;
    step(acc);
    start = 1'b0;
    check_eq("busy_start", 96'(busy), 96'(1'b1));
    check_eq("ovf_clr", 96'(ovf_err), 96'(1'b0));
    i = 0;
    cyc = 0;
    d = all_ff ? '1 : {$urandom, $urandom};
    while (i < nb && cyc < 200) begin
      m_data = d;
      m_data_first = (i == 0);
      m_data_last = (i == nb - 1);
      m_data_valid = 1'b1;
      if (cyc == restart_at) begin
        start = 1'b1;
        winfo = {3'd5, 1'b0, ~rs, 2'b00};
        base_addr = base + 14'h0200;
      end else begin
        start = 1'b0;
      end
      trdy = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (rs) begin
        s_data_ready2 = trdy;
        s_data_ready1 = 1'($urandom_range(0, 1));
      end else begin
        s_data_ready1 = trdy;
        s_data_ready2 = 1'($urandom_range(0, 1));
      end
      step(acc);
      if (acc) begin
        i++;
        d = all_ff ? '1 : {$urandom, $urandom};
      end
      cyc++;
    end
    start = 1'b0;
    m_data_valid = 1'b0;
    m_data_first = 1'b0;
    m_data_last = 1'b0;
    s_data_ready1 = 1'b1;
    s_data_ready2 = 1'b1;
    check_eq("beats_sent", 96'(i), 96'(nb));
    w = 0;
    while (!done && w < 50) begin
      step(acc);
      w++;
    end
    check_eq("done_seen", 96'(done), 96'(1'b1));
    check_eq("done_lat", 96'(step_n), 96'(last_pop_step + 1));
    check_eq("busy_done", 96'(busy), 96'(1'b0));
    check_eq("sb_drained", 96'(exp_q.size()), 96'(0));
    check_eq("ovf_sticky", 96'(ovf_err), 96'(exp_ovf));
    step(acc);
    check_eq("done_pulse", 96'(done), 96'(1'b0));
    check_eq("idle_after", 96'(dbg_state), 96'(2'd0));
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    start = 1'b0;
    winfo = '0;
    base_addr = '0;
    m_data = '0;
    m_data_first = 1'b0;
    m_data_last = 1'b0;
    m_data_valid = 1'b0;
    s_data_ready1 = 1'b1;
    s_data_ready2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(acc);
    rst = 1'b0;
    check_eq("rst_v1", 96'(s_data_valid1), 96'(1'b0));
    check_eq("rst_v2", 96'(s_data_valid2), 96'(1'b0));
    check_eq("rst_busy", 96'(busy), 96'(1'b0));
    check_eq("rst_done", 96'(done), 96'(1'b0));
    check_eq("rst_ovf", 96'(ovf_err), 96'(1'b0));
    check_eq("rst_addr", 96'(s_addr), 96'(0));
    check_eq("rst_data", 96'(s_data), 96'(0));
    check_eq("rst_mready", 96'(m_data_ready), 96'(1'b0));
    check_eq("rst_state", 96'(dbg_state), 96'(2'd0));

    // RAM1, all lanes, sequential addresses from 0x010
    run_job(14'h0010, 1'b0, 3'd0, 4, 1'b0, -1, 0, -1, 1'b0);
    // RAM2, channel 3 lane masking
    run_job(14'h0020, 1'b1, 3'd3, 3, 1'b1, -1, 0, -1, 1'b0);
    check_eq("ch3_data", 96'(last_sdata), 96'(64'h0000_0000_00FF_FFFF));
    // RAM2 back-pressure mid-job
    run_job(14'h0040, 1'b1, 3'd0, 6, 1'b0, 2, 3, -1, 1'b0);
    // address wrap sets the sticky overflow flag
    run_job(14'h3FFE, 1'b0, 3'd2, 3, 1'b0, -1, 0, -1, 1'b1);
    // start during RUN must be ignored; also clears ovf at its own start
    run_job(14'h0080, 1'b0, 3'd7, 5, 1'b0, -1, 0, 1, 1'b0);
    // RAM1 back-pressure with random other-side ready
    run_job(14'h00C0, 1'b0, 3'd4, 5, 1'b0, 1, 2, -1, 1'b0);

    // reset while a held beat is stalled
    winfo = {3'd0, 1'b0, 1'b0, 2'b00};
    base_addr = 14'h0100;
    start = 1'b1;
    model_rs = 1'b0;
    model_ch = 3'd0;
    model_addr = 14'h0100;
    step(acc);
    start = 1'b0;
    s_data_ready1 = 1'b0;
    m_data = {$urandom, $urandom};
    m_data_first = 1'b1;
    m_data_last = 1'b0;
    m_data_valid = 1'b1;
    step(acc);
    m_data_valid = 1'b0;
    step(acc);
    step(acc);
    check_eq("stall_held", 96'(s_data_valid1), 96'(1'b1));
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    exp_q.delete();
    check_eq("rst2_v1", 96'(s_data_valid1), 96'(1'b0));
    check_eq("rst2_v2", 96'(s_data_valid2), 96'(1'b0));
    check_eq("rst2_busy", 96'(busy), 96'(1'b0));
    check_eq("rst2_done", 96'(done), 96'(1'b0));
    check_eq("rst2_state", 96'(dbg_state), 96'(2'd0));
    s_data_ready1 = 1'b1;
    run_job(14'h0123, 1'b1, 3'd1, 4, 1'b0, -1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
